// File: rtl/txrsp_lnk_if.sv
// RSP flit layout and the protocol-side / link-side signal bundle of the TXRSP link layer.
// The master modport is the traffic source and credit returner; the slave modport is txrsp_lnk.
package txrsp_lnk_pkg;

  typedef struct packed {
    logic [6:0] tgtid;
    logic [6:0] srcid;
    logic [7:0] txnid;
    logic [3:0] opcode;
    logic [2:0] resp;
    logic [7:0] dbid;
  } rspflit_t;

  localparam logic [3:0] RESP_LCRD_RETURN = 4'd0;

endpackage

interface txrsp_lnk_if;
  import txrsp_lnk_pkg::*;

  logic     pin_valid;
  logic     pin_ready;
  rspflit_t txrsp_flit_i;
  logic     txrspflitpend;
  logic     txrspflitv;
  rspflit_t txrspflit;
  logic     txrsplcrdv;

  modport master (
    output pin_valid, txrsp_flit_i, txrsplcrdv,
    input  pin_ready, txrspflitpend, txrspflitv, txrspflit
  );

  modport slave (
    input  pin_valid, txrsp_flit_i, txrsplcrdv,
    output pin_ready, txrspflitpend, txrspflitv, txrspflit
  );

endinterface

// File: rtl/txrsp_lnk.sv
// CHI TXRSP link layer: buffers response flits and sends them against link credits.
// Define TXRSP_DEACT_EN to build the DRAIN/RETURN/DONE link deactivation sequence.
module txrsp_lnk
  import txrsp_lnk_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter int  MAX_CRD = 15,
  localparam int CRD_W   = $clog2(MAX_CRD + 1)
) (
  input  logic             clock,
  input  logic             reset,
  txrsp_lnk_if.slave       lnk,
  input  logic             deact_req,
  output logic             deact_done,
  output logic [CRD_W-1:0] crd_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CRD_W-1:0] CRD_TOP  = CRD_W'(MAX_CRD);

  typedef enum logic [1:0] {RUN, DRAIN, RETURN, DONE} state_t;

  rspflit_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic [CRD_W-1:0] r_crd;
  state_t           r_state;
  logic             r_pinReady;
  logic             r_flitPend;
  logic             r_flitV;
  rspflit_t         r_flit;

  logic             w_push;
  logic             w_pop;
  logic             w_genRet;
  logic             w_send;
  logic [CNT_W-1:0] w_nextCount;
  logic [CRD_W-1:0] w_nextCrd;
  state_t           w_nextState;
  rspflit_t         w_retFlit;

  assign w_push   = lnk.pin_valid && r_pinReady;
  assign w_pop    = ((r_state == RUN) || (r_state == DRAIN)) && (r_count != '0) && (r_crd != '0);
  assign w_genRet = (r_state == RETURN) && (r_crd != '0);
  assign w_send   = w_pop || w_genRet;

  always_comb begin
    w_retFlit        = '0;
    w_retFlit.opcode = RESP_LCRD_RETURN;
  end

  always_comb begin
    w_nextCount = r_count;
    case ({w_push, w_pop})
      2'b10:   w_nextCount = r_count + CNT_W'(1);
      2'b01:   w_nextCount = r_count - CNT_W'(1);
      default: w_nextCount = r_count;
    endcase
  end

  // A credit arriving with the counter already full is a receiver error and is dropped.
  always_comb begin
    w_nextCrd = r_crd;
    if (lnk.txrsplcrdv && !w_send) begin
      if (r_crd != CRD_TOP) begin
        w_nextCrd = r_crd + CRD_W'(1);
      end
    end else if (!lnk.txrsplcrdv && w_send) begin
      w_nextCrd = r_crd - CRD_W'(1);
    end
  end

`ifdef TXRSP_DEACT_EN
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN:     if (deact_req) w_nextState = DRAIN;
      DRAIN:   if (r_count == '0) w_nextState = RETURN;
      RETURN:  if ((r_crd == '0) && !lnk.txrsplcrdv) w_nextState = DONE;
      DONE: begin
        if (lnk.txrsplcrdv) begin
          w_nextState = RETURN;
        end else if (!deact_req) begin
          w_nextState = RUN;
        end
      end
      default: w_nextState = RUN;
    endcase
  end
`else
  logic w_unusedDeact;
  assign w_unusedDeact = deact_req;

  always_comb begin
    w_nextState = RUN;
  end
`endif

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= lnk.txrsp_flit_i;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PTR_W'(1);
      end
      r_count <= w_nextCount;
    end
  end

  // Handshake and pend flags are built from next-state values so they are valid the cycle they are seen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_crd      <= '0;
      r_pinReady <= 1'b0;
      r_flitPend <= 1'b0;
      r_flitV    <= 1'b0;
      r_flit     <= '0;
    end else begin
      r_state    <= w_nextState;
      r_crd      <= w_nextCrd;
      r_pinReady <= (w_nextCount < FULL_CNT) && (w_nextState == RUN);
      r_flitPend <= (w_nextCount != '0) || ((w_nextState == RETURN) && (w_nextCrd != '0));
      r_flitV    <= w_send;
      r_flit     <= w_pop ? r_mem[r_rdPtr] : (w_genRet ? w_retFlit : '0);
    end
  end

`ifdef TXRSP_DEACT_EN
  logic r_deactDone;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_deactDone <= 1'b0;
    end else begin
      r_deactDone <= (w_nextState == DONE);
    end
  end

  assign deact_done = r_deactDone;
`else
  assign deact_done = 1'b0;
`endif

  assign lnk.pin_ready     = r_pinReady;
  assign lnk.txrspflitpend = r_flitPend;
  assign lnk.txrspflitv    = r_flitV;
  assign lnk.txrspflit     = r_flit;
  assign crd_cnt           = r_crd;

endmodule

// File: tb/tb_txrsp_lnk.sv
// Testbench for txrsp_lnk: directed scenarios plus random traffic against a queue-based
// reference model of the flit buffer and credit counter.
module tb_txrsp_lnk;
  import txrsp_lnk_pkg::*;

  localparam int DEPTH   = 2;
  localparam int MAX_CRD = 15;
  localparam int CRD_W   = $clog2(MAX_CRD + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             deact_req = 1'b0;
  logic             deact_done;
  logic [CRD_W-1:0] crd_cnt;

  txrsp_lnk_if lnk ();

  txrsp_lnk #(.DEPTH(DEPTH), .MAX_CRD(MAX_CRD)) dut (
    .clock      (clock),
    .reset      (reset),
    .lnk        (lnk),
    .deact_req  (deact_req),
    .deact_done (deact_done),
    .crd_cnt    (crd_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int sentCount = 0;
  bit modelOn = 1'b1;

  // Reference model: the buffer as a queue of accepted flits, credits as a plain saturating integer.
  rspflit_t mQ[$];
  int       mCrd;
  bit       mReady;
  bit       mPend;
  bit       expV;
  rspflit_t expFlit;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic rspflit_t mkFlit(input int txnid);
    rspflit_t f;
    f.tgtid  = 7'($urandom());
    f.srcid  = 7'($urandom());
    f.txnid  = 8'(txnid);
    f.opcode = 4'(1 + ($urandom() % 15));
    f.resp   = 3'($urandom());
    f.dbid   = 8'($urandom());
    return f;
  endfunction

  task automatic modelReset();
    mQ.delete();
    mCrd    = 0;
    mReady  = 1'b0;
    mPend   = 1'b0;
    expV    = 1'b0;
    expFlit = '0;
  endtask

  // One clock cycle: drive inputs, advance the model, then compare just after the edge.
  task automatic applyStimulus(input bit v, input rspflit_t f, input bit lcrd, input bit dreq);
    bit send;
    lnk.pin_valid    = v;
    lnk.txrsp_flit_i = f;
    lnk.txrsplcrdv   = lcrd;
    deact_req        = dreq;
    send = (mQ.size() > 0) && (mCrd > 0);
    expV = send;
    expFlit = send ? mQ.pop_front() : '0;
    if (v && mReady) mQ.push_back(f);
    mCrd = mCrd + int'(lcrd) - int'(send);
    if (mCrd > MAX_CRD) mCrd = MAX_CRD;
    mReady = (mQ.size() < DEPTH);
    mPend  = (mQ.size() > 0);
    @(posedge clock);
    #1;
    if (lnk.txrspflitv) sentCount++;
    if (modelOn) begin
      checkOutput("flitv", 64'(lnk.txrspflitv), 64'(expV));
      if (expV) checkOutput("flit", 64'(lnk.txrspflit), 64'(expFlit));
      checkOutput("crd_cnt", 64'(crd_cnt), 64'(mCrd));
      checkOutput("pin_ready", 64'(lnk.pin_ready), 64'(mReady));
      checkOutput("flitpend", 64'(lnk.txrspflitpend), 64'(mPend));
      checkOutput("deact_done", 64'(deact_done), 64'(0));
    end
  endtask

  task automatic idle(input int n, input bit dreq);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, dreq);
  endtask

  task automatic pushFlit(input rspflit_t f, input bit dreq);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      acc = mReady;
      applyStimulus(1'b1, f, 1'b0, dreq);
      n++;
    end
    if (!acc) checkOutput("push_timeout", 64'(acc), 64'(1));
  endtask

  task automatic doReset();
    reset = 1'b0;
    lnk.pin_valid = 1'b0;
    lnk.txrsp_flit_i = '0;
    lnk.txrsplcrdv = 1'b0;
    deact_req = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
  endtask

  // Asserts reset between edges and checks the link and credits clear without waiting for a clock.
  task automatic midReset(input string tag);
    #1 reset = 1'b0;
    #1;
    checkOutput({tag, "_flitv"}, 64'(lnk.txrspflitv), 64'(0));
    checkOutput({tag, "_crd"}, 64'(crd_cnt), 64'(0));
    lnk.pin_valid = 1'b0;
    lnk.txrsplcrdv = 1'b0;
    deact_req = 1'b0;
    modelReset();
    @(posedge clock);
    #2 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rspflit_t f5;
    rspflit_t fa;
    rspflit_t fb;
    rspflit_t obs[$];
    int n;

    reset = 1'b0;
    lnk.pin_valid = 1'b0;
    lnk.txrsp_flit_i = '0;
    lnk.txrsplcrdv = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_pin_ready", 64'(lnk.pin_ready), 64'(0));
    checkOutput("rst_flitpend", 64'(lnk.txrspflitpend), 64'(0));
    checkOutput("rst_flitv", 64'(lnk.txrspflitv), 64'(0));
    checkOutput("rst_flit", 64'(lnk.txrspflit), 64'(0));
    checkOutput("rst_deact_done", 64'(deact_done), 64'(0));
    checkOutput("rst_crd", 64'(crd_cnt), 64'(0));
    #1 reset = 1'b1;

    $display("[TB] single flit waits for a credit");
    idle(1, 1'b0);
    checkOutput("ready_after_release", 64'(lnk.pin_ready), 64'(1));
    f5 = mkFlit(5);
    pushFlit(f5, 1'b0);
    checkOutput("pend_one", 64'(lnk.txrspflitpend), 64'(1));
    idle(3, 1'b0);
    checkOutput("no_send_without_crd", 64'(lnk.txrspflitv), 64'(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("crd_granted", 64'(crd_cnt), 64'(1));
    idle(1, 1'b0);
    checkOutput("first_flitv", 64'(lnk.txrspflitv), 64'(1));
    checkOutput("first_txnid", 64'(lnk.txrspflit.txnid), 64'(5));
    checkOutput("first_crd_zero", 64'(crd_cnt), 64'(0));

    $display("[TB] four credits, six flits");
    idle(1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    sentCount = 0;
    for (int i = 0; i < 6; i++) pushFlit(mkFlit(10 + i), 1'b0);
    idle(2, 1'b0);
    checkOutput("sent_four", 64'(sentCount), 64'(4));
    checkOutput("ready_low_two_left", 64'(lnk.pin_ready), 64'(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    idle(1, 1'b0);
    checkOutput("fifth_txnid", 64'(lnk.txrspflit.txnid), 64'(14));
    checkOutput("sent_five", 64'(sentCount), 64'(5));

    $display("[TB] simultaneous credit and send, saturation");
    doReset();
    idle(1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    pushFlit(mkFlit(33), 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("send_and_crd_v", 64'(lnk.txrspflitv), 64'(1));
    checkOutput("send_and_crd_cnt", 64'(crd_cnt), 64'(3));
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("crd_saturated", 64'(crd_cnt), 64'(15));

    $display("[TB] random traffic");
    doReset();
    idle(1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom() % 2), mkFlit(int'($urandom() % 256)),
                    ($urandom() % 100) < 35, 1'b0);
    end
    n = 0;
    while (mQ.size() > 0 && n < 20) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    idle(1, 1'b0);
    checkOutput("random_drained", 64'(lnk.txrspflitpend), 64'(0));

`ifdef TXRSP_DEACT_EN
    $display("[TB] deactivation: drain then return credits");
    doReset();
    idle(1, 1'b0);
    modelOn = 1'b0;
    fa = mkFlit(71);
    fb = mkFlit(72);
    pushFlit(fa, 1'b0);
    pushFlit(fb, 1'b0);
    obs.delete();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1);
      if (lnk.txrspflitv) obs.push_back(lnk.txrspflit);
    end
    n = 0;
    while (!deact_done && n < 40) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      if (lnk.txrspflitv) obs.push_back(lnk.txrspflit);
      n++;
    end
    checkOutput("deact_done_set", 64'(deact_done), 64'(1));
    checkOutput("deact_crd_zero", 64'(crd_cnt), 64'(0));
    checkOutput("deact_flit_count", 64'(obs.size()), 64'(5));
    if (obs.size() == 5) begin
      checkOutput("deact_data0", 64'(obs[0]), 64'(fa));
      checkOutput("deact_data1", 64'(obs[1]), 64'(fb));
      for (int i = 2; i < 5; i++) checkOutput("deact_lcrdreturn", 64'(obs[i]), 64'(0));
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("deact_exit_ready", 64'(lnk.pin_ready), 64'(1));
    checkOutput("deact_exit_done", 64'(deact_done), 64'(0));

    $display("[TB] reset during credit return");
    doReset();
    idle(1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    n = 0;
    while (crd_cnt != CRD_W'(2) && n < 10) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      n++;
    end
    checkOutput("return_two_left", 64'(crd_cnt), 64'(2));
    checkOutput("return_flitv", 64'(lnk.txrspflitv), 64'(1));
    midReset("ret_reset");
    modelOn = 1'b1;
    idle(1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    idle(3, 1'b0);
`else
    $display("[TB] deact_req ignored without deactivation support");
    doReset();
    idle(1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    sentCount = 0;
    for (int i = 0; i < 3; i++) pushFlit(mkFlit(90 + i), 1'b1);
    idle(4, 1'b1);
    checkOutput("nodeact_sent", 64'(sentCount), 64'(2));
    checkOutput("nodeact_crd", 64'(crd_cnt), 64'(0));
    checkOutput("nodeact_done", 64'(deact_done), 64'(0));

    $display("[TB] reset with flits buffered and credits held");
    doReset();
    idle(1, 1'b0);
    pushFlit(mkFlit(51), 1'b0);
    pushFlit(mkFlit(52), 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("pre_reset_flitv", 64'(lnk.txrspflitv), 64'(1));
    checkOutput("pre_reset_crd", 64'(crd_cnt), 64'(1));
    midReset("op_reset");
    idle(1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    idle(3, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
